// File: rtl/smem_call_tracker_if.sv
// smem_call_tracker_if: pc stream in, session status out; master drives pc, slave is the tracker.
interface smem_call_tracker_if;
  logic [15:0] pc;
  logic        pc_en;
  logic        busy;
  logic        done;
  logic        violation;
  logic [15:0] caller_pc;
  logic [7:0]  sess_cnt;
  modport master (output pc, pc_en, input busy, done, violation, caller_pc, sess_cnt);
  modport slave  (input pc, pc_en, output busy, done, violation, caller_pc, sess_cnt);
endinterface

// File: rtl/smem_call_tracker.sv
// smem_call_tracker: polices entry/exit of the secure memory window; return-address check when SMEM_RET_CHECK_EN is defined.
`ifndef SMEM_BASE
`define SMEM_BASE 16'hA000
`endif
`ifndef SMEM_SIZE
`define SMEM_SIZE 16'h1000
`endif
module smem_call_tracker (
  input logic clk,
  input logic puc_rst,
  smem_call_tracker_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ENTRY, INSIDE, LAST, KILL} state_t;
  localparam logic [15:0] FIRST_A = `SMEM_BASE;
  localparam logic [15:0] LAST_A  = `SMEM_BASE + `SMEM_SIZE - 16'd2;
  state_t      state_q, state_d;
  logic [15:0] prev_q, prev_d, caller_q, caller_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        is_first, is_last, is_mid, is_out, ret_ok;
  assign is_first = bus.pc == FIRST_A;
  assign is_last  = bus.pc == LAST_A;
  assign is_mid   = bus.pc > FIRST_A && bus.pc < LAST_A;
  assign is_out   = bus.pc < FIRST_A || bus.pc > LAST_A;
`ifdef SMEM_RET_CHECK_EN
  assign ret_ok = bus.pc == caller_q + 16'd2 || bus.pc == caller_q + 16'd4;
`else
  assign ret_ok = 1'b1;
`endif
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    caller_d = caller_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    if (bus.pc_en) begin
      case (state_q)
        IDLE: begin
          prev_d = bus.pc;
          if (is_first) begin
            state_d  = ENTRY;
            caller_d = prev_q;
          end else if (!is_out) state_d = KILL;
        end
        ENTRY:  state_d = is_first ? ENTRY : is_mid ? INSIDE : KILL;
        INSIDE: state_d = is_mid ? INSIDE : is_last ? LAST : KILL;
        LAST: begin
          if (is_out && ret_ok) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = cnt_q + {7'd0, cnt_q != 8'hFF};
          end else if (!is_last) state_d = KILL;
        end
        KILL:    state_d = bus.pc == 16'h0000 ? IDLE : KILL;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (puc_rst) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      caller_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      caller_q <= caller_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end
  assign bus.busy      = state_q inside {ENTRY, INSIDE, LAST};
  assign bus.violation = state_q == KILL;
  assign bus.done      = done_q;
  assign bus.caller_pc = caller_q;
  assign bus.sess_cnt  = cnt_q;
endmodule

// File: tb/tb_smem_call_tracker.sv
// tb_smem_call_tracker: directed and random pc streams against a table-driven session model.
module tb_smem_call_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  smem_call_tracker_if bus ();
  smem_call_tracker dut (.clk(clk), .puc_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // model phases: 0 idle, 1 entered, 2 inside, 3 at last, 4 killed
  int          nxt [5][4];
  int          m_ph;
  logic [15:0] m_prev, m_caller;
  logic [7:0]  m_cnt;
  logic        m_done;
  function automatic int cls(input logic [15:0] p);
    if (p == 16'hA000) return 1;
    if (p == 16'hAFFE) return 3;
    if (p > 16'hA000 && p < 16'hAFFE) return 2;
    return 0;
  endfunction
  function automatic logic legal_ret(input logic [15:0] p, input logic [15:0] c);
`ifdef SMEM_RET_CHECK_EN
    logic [15:0] a, b;
    a = c + 16'd2;
    b = c + 16'd4;
    return p == a || p == b;
`else
    return 1'b1;
`endif
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [15:0] p, input logic en, input logic r);
    int c;
    bus.pc = p;
    bus.pc_en = en;
    rst = r;
    @(posedge clk);
    c = cls(p);
    m_done = 1'b0;
    if (r) begin
      m_ph = 0; m_prev = '0; m_caller = '0; m_cnt = '0;
    end else if (en) begin
      if (m_ph == 0) begin
        if (c == 1) m_caller = m_prev;
        m_prev = p;
      end
      if (m_ph == 4) m_ph = (p == 16'h0000) ? 0 : 4;
      else if (m_ph == 3 && c == 0) begin
        if (legal_ret(p, m_caller)) begin
          m_ph = 0;
          m_done = 1'b1;
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end else m_ph = 4;
      end else m_ph = nxt[m_ph][c];
    end
    #1;
    chk("busy", {15'd0, bus.busy}, {15'd0, m_ph >= 1 && m_ph <= 3});
    chk("done", {15'd0, bus.done}, {15'd0, m_done});
    chk("violation", {15'd0, bus.violation}, {15'd0, m_ph == 4});
    chk("caller_pc", bus.caller_pc, m_caller);
    chk("sess_cnt", {8'd0, bus.sess_cnt}, {8'd0, m_cnt});
  endtask
  task automatic session(input logic [15:0] ret);
    step(16'hE000, 1, 0);
    step(16'hA000, 1, 0);
    step(16'hA010, 1, 0);
    step(16'hAFFE, 1, 0);
    step(ret, 1, 0);
  endtask
  initial begin
    // classes: 0 outside, 1 first, 2 mid, 3 last
    nxt[0] = '{0, 1, 4, 4};
    nxt[1] = '{4, 1, 2, 4};
    nxt[2] = '{4, 4, 2, 3};
    nxt[3] = '{4, 4, 4, 3};
    nxt[4] = '{4, 4, 4, 4};
    m_ph = 0; m_prev = '0; m_caller = '0; m_cnt = '0; m_done = 1'b0;
    bus.pc = 16'h1234;
    bus.pc_en = 1'b1;
    step(16'hA000, 1, 1);
    step(16'hA010, 1, 1);
    session(16'hE004);
    chk("legal_cnt", {8'd0, bus.sess_cnt}, 16'd1);
    chk("legal_caller", bus.caller_pc, 16'hE000);
    step(16'hA010, 1, 0);
    step(16'hE000, 1, 0);
    step(16'h0000, 1, 0);
    session(16'hE008);
    step(16'h0000, 1, 0);
    session(16'hE002);
    step(16'hA000, 1, 0);
    step(16'hE002, 1, 0);
    step(16'h0000, 1, 0);
    step(16'hA000, 1, 0);
    for (int i = 0; i < 5; i++) step(16'hA010, 0, 0);
    step(16'hA010, 1, 0);
    step(16'hA020, 1, 1);
    step(16'hAFFE, 1, 0);
    step(16'h0000, 1, 0);
    step(16'h9FFE, 1, 0);
    step(16'hA000, 1, 0);
    step(16'hA002, 1, 0);
    step(16'hAFFE, 1, 0);
    step(16'hAFFF, 1, 0);
    step(16'h0000, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] p;
      case ($urandom_range(0, 7))
        0: p = 16'hA000;
        1: p = 16'hAFFE;
        2: p = 16'($urandom_range(16'hA001, 16'hAFFD));
        3: p = 16'($urandom_range(0, 16'h9FFF));
        4: p = 16'($urandom_range(16'hAFFF, 16'hFFFF));
        5: p = m_caller + 16'd2;
        6: p = m_caller + 16'd4;
        default: p = 16'h0000;
      endcase
      step(p, $urandom_range(0, 4) != 0, $urandom_range(0, 59) == 0);
    end
    step(16'h0000, 1, 1);
    for (int i = 0; i < 256; i++) session(16'hE004);
    chk("sat_cnt", {8'd0, bus.sess_cnt}, 16'h00FF);
    session(16'hE002);
    chk("sat_hold", {8'd0, bus.sess_cnt}, 16'h00FF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/smem_call_tracker.md
SMEM_CALL_TRACKER -- requirements
Module: smem_call_tracker

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 puc_rst  input  1  synchronous active-high reset.
REQ-004 pc  input  16  current program counter.
REQ-005 pc_en  input  1  pc-valid strobe; the FSM evaluates pc only when high.
REQ-006 busy  output  1  high while a SMEM session is open (states ENTRY, INSIDE, LAST).
REQ-007 done  output  1  one-cycle pulse on a legal session return.
REQ-008 violation  output  1  reset request to the core; level signal.
REQ-009 caller_pc  output  16  pc of the last pc_en cycle before SMEM entry.
REQ-010 sess_cnt  output  8  count of completed legal sessions.

Function
REQ-011 Address classes SHALL use first = `SMEM_BASE, last = `SMEM_BASE + `SMEM_SIZE - 2, mid = strictly between first and last, outside = below first or above last.
REQ-012 States SHALL be IDLE, ENTRY, INSIDE, LAST and KILL.
REQ-013 With pc_en low, state, prev_pc, caller_pc and sess_cnt SHALL hold, and done SHALL be 0.
REQ-014 prev_pc SHALL load pc on every pc_en cycle while in IDLE.
REQ-015 IDLE transitions:
- first -> ENTRY, with caller_pc <= prev_pc.
- mid or last -> KILL.
- outside -> stay.
REQ-016 ENTRY transitions:
- first -> stay.
- mid -> INSIDE.
- last or outside -> KILL.
REQ-017 INSIDE transitions:
- mid -> stay.
- last -> LAST.
- first or outside -> KILL.
REQ-018 LAST transitions:
- last -> stay.
- first or mid -> KILL.
- outside with a legal return (REQ-019) -> IDLE, done pulse, sess_cnt increment.
- outside with an illegal return -> KILL.
REQ-019 A legal return SHALL be pc == caller_pc + 2 or pc == caller_pc + 4, with the sum computed modulo 2^16.
REQ-020 KILL SHALL go to IDLE when pc_en is high and pc == 16'h0000; otherwise KILL SHALL hold.
REQ-021 violation, done, busy and sess_cnt SHALL be registered: each reflects the transition one clock after the deciding pc_en cycle.
REQ-022 violation SHALL be 1 exactly while the state is KILL.
REQ-023 sess_cnt SHALL saturate at 8'hFF with no wrap.
REQ-024 caller_pc SHALL hold its value from ENTRY until the next entry, including across KILL.
REQ-025 A single-instruction session (first immediately followed by outside) SHALL be a violation, because ENTRY must pass through mid and LAST.

Reset
REQ-026 puc_rst high at a rising edge SHALL force all of the following, overriding any simultaneous pc_en event:
- state IDLE
- violation 0, done 0, busy 0
- sess_cnt 8'h00, caller_pc 16'h0000, prev_pc 16'h0000
REQ-027 puc_rst asserted mid-session (ENTRY, INSIDE or LAST) SHALL discard the session without a done pulse or sess_cnt increment.

Configuration
REQ-028 Macro SMEM_RET_CHECK_EN SHALL select the exit rule.
REQ-029 With SMEM_RET_CHECK_EN defined, REQ-019 SHALL apply.
REQ-030 Without SMEM_RET_CHECK_EN, any outside pc from LAST SHALL be a legal return; caller_pc SHALL still be latched.

Verification
Example parameters: `SMEM_BASE = 16'hA000, `SMEM_SIZE = 16'h1000, so last = 16'hAFFE.
REQ-031 Legal session: pc_en pcs E000, A000, A010, AFFE, E004 -> busy 1 from the A000 step; done pulse after E004; caller_pc = E000; sess_cnt = 1; violation 0.
REQ-032 Mid entry: from IDLE, pc A010 -> violation 1 next clock; stays 1 through pc E000; pc 0000 -> violation 0 next clock, state IDLE.
REQ-033 Bad return (SMEM_RET_CHECK_EN defined): E000, A000, A010, AFFE, E008 -> violation 1, no done, sess_cnt unchanged. Without the macro, the same sequence -> done pulse, sess_cnt increments.
REQ-034 pc_en gating: A000 with pc_en, then A010 with pc_en low for 5 cycles -> state ENTRY holds, busy 1, no violation.
REQ-035 Reset mid-session: puc_rst in INSIDE -> next clock busy 0, sess_cnt 0, caller_pc 0000, no done.
REQ-036 Saturation: 256 legal sessions -> sess_cnt = FF; the 256th still pulses done.
